// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// One word-RAM port bundle, the same signal set a direct-mapped write-back
// cache drives toward memory.
//   address    : byte address of the current beat
//   rd, wr     : read / write strobes, held until data_valid
//   data_wr    : write data for the current beat
//   data_rd    : read data returned for the current beat
//   data_valid : one pulse per completed word
// Modports:
//   master : the side that issues requests (a cache, or the arbiter toward RAM)
//   slave  : the side that services requests (the RAM, or the arbiter toward a cache)
interface ram_arbiter_if #(
    parameter int ADDRESS_WIDTH = 16
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     rd;
    logic                     wr;
    logic [31:0]              data_wr;
    logic [31:0]              data_rd;
    logic                     data_valid;

    modport master (
        output address, rd, wr, data_wr,
        input  data_rd, data_valid
    );

    modport slave (
        input  address, rd, wr, data_wr,
        output data_rd, data_valid
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one external word-RAM port between two cache requesters. Grants
// are round-robin and are held for a whole cache-line burst of
// 2**WORD_OFFSET_WIDTH beats, so writeback and fetch beats from different
// caches never interleave on the RAM port.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   m0, m1       : requester ports (slave side of ram_arbiter_if)
//   ram          : shared RAM port (master side of ram_arbiter_if)
//   grant        : one-hot current owner, 00 while idle
//   arb_timeout  : sticky flag, set when a burst stalls for TIMEOUT_CYCLES
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abandon a burst that sees
// no ram data_valid for TIMEOUT_CYCLES cycles. Without it arb_timeout is
// tied low and a stalled burst keeps its grant indefinitely.
module ram_arbiter #(
    parameter int ADDRESS_WIDTH     = 16,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          m0,
    ram_arbiter_if.slave          m1,
    ram_arbiter_if.master         ram,
    output logic [1:0]            grant,
    output logic                  arb_timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Beat counter is exactly WORD_OFFSET_WIDTH bits, so the last beat of a
    // burst is the all-ones value.
    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_BEAT = '1;
    localparam logic [ADDRESS_WIDTH-1:0]     ADDR_ZERO = '0;

    state_t                       state_r, state_next;
    logic                         owner_r, owner_next;
    logic                         last_owner_r, last_owner_next;
    logic [WORD_OFFSET_WIDTH-1:0] beat_count_r, beat_count_next;
    logic [1:0]                   grant_next;
    logic                         req0, req1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0]           stall_count_r, stall_count_next;
    logic                         timeout_r, timeout_next;

    assign arb_timeout = timeout_r;
`else
    logic                         unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign arb_timeout        = 1'b0;
`endif

    assign req0 = m0.rd | m0.wr;
    assign req1 = m1.rd | m1.wr;

    // State register. The grant vector is registered alongside the owner so
    // it changes exactly on the cycle the lock is taken or released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
            last_owner_r  <= 1'b1;
            beat_count_r  <= '0;
            grant         <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
            stall_count_r <= '0;
            timeout_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_next;
            owner_r       <= owner_next;
            last_owner_r  <= last_owner_next;
            beat_count_r  <= beat_count_next;
            grant         <= grant_next;
`ifdef MEM_ARB_TIMEOUT_EN
            stall_count_r <= stall_count_next;
            timeout_r     <= timeout_next;
`endif
        end
    end

    // Arbitration and burst tracking. A tie goes to the port that did not
    // own the previous burst; last_owner_r resets to 1 so port 0 wins the
    // first tie. Once granted, only ram data_valid beats (or a stall
    // timeout) end the lock; the owner dropping its strobes does not.
    always_comb begin
        state_next       = state_r;
        owner_next       = owner_r;
        last_owner_next  = last_owner_r;
        beat_count_next  = beat_count_r;
`ifdef MEM_ARB_TIMEOUT_EN
        stall_count_next = stall_count_r;
        timeout_next     = timeout_r;
`endif
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_next       = BUSY;
                    owner_next       = (req0 && req1) ? ~last_owner_r : req1;
                    beat_count_next  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    stall_count_next = '0;
`endif
                end
            end
            BUSY: begin
                if (ram.data_valid) begin
                    beat_count_next  = beat_count_r + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    stall_count_next = '0;
`endif
                    if (beat_count_r == LAST_BEAT) begin
                        state_next      = IDLE;
                        last_owner_next = owner_r;
                        beat_count_next = '0;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (stall_count_r == TIMER_LIMIT) begin
                    state_next       = IDLE;
                    last_owner_next  = owner_r;
                    beat_count_next  = '0;
                    stall_count_next = '0;
                    timeout_next     = 1'b1;
                end else begin
                    stall_count_next = stall_count_r + 1'b1;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        grant_next = 2'b00;
        if (state_next == BUSY) begin
            grant_next = owner_next ? 2'b10 : 2'b01;
        end
    end

    // Bus routing from the registered owner. While idle the RAM port is
    // fully quiet and neither requester sees data, so a stray RAM
    // data_valid is dropped. Read data fans out to both ports during a
    // burst but only the owner receives the valid strobe.
    always_comb begin
        ram.address     = ADDR_ZERO;
        ram.rd          = 1'b0;
        ram.wr          = 1'b0;
        ram.data_wr     = '0;
        m0.data_rd      = '0;
        m1.data_rd      = '0;
        m0.data_valid   = 1'b0;
        m1.data_valid   = 1'b0;
        if (state_r == BUSY) begin
            m0.data_rd = ram.data_rd;
            m1.data_rd = ram.data_rd;
            if (owner_r) begin
                ram.address   = m1.address;
                ram.rd        = m1.rd;
                ram.wr        = m1.wr;
                ram.data_wr   = m1.data_wr;
                m1.data_valid = ram.data_valid;
            end else begin
                ram.address   = m0.address;
                ram.rd        = m0.rd;
                ram.wr        = m0.wr;
                ram.data_wr   = m0.data_wr;
                m0.data_valid = ram.data_valid;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. Each scenario task drives requester
// and RAM stimulus (with $urandom data and valid timing) and compares the
// DUT against a cycle-level reference model of the arbitration rules:
// who owns the RAM, how many beats have been delivered, who owned last.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW        = 16;
    localparam int WOW       = 2;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] grant;
    logic       arb_timeout;

    int checks   = 0;
    int failures = 0;

    ram_arbiter_if #(.ADDRESS_WIDTH(AW)) m0_bus ();
    ram_arbiter_if #(.ADDRESS_WIDTH(AW)) m1_bus ();
    ram_arbiter_if #(.ADDRESS_WIDTH(AW)) ram_bus ();

    ram_arbiter #(
        .ADDRESS_WIDTH    (AW),
        .WORD_OFFSET_WIDTH(WOW),
        .TIMEOUT_CYCLES   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .ram        (ram_bus),
        .grant      (grant),
        .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner is -1 when idle, beats counts delivered words.
    int   mdl_owner   = -1;
    int   mdl_beats   = 0;
    int   mdl_last    = 1;
    int   mdl_stall   = 0;
    logic mdl_timeout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_owner   = -1;
            mdl_beats   = 0;
            mdl_last    = 1;
            mdl_stall   = 0;
            mdl_timeout = 1'b0;
        end else if (mdl_owner < 0) begin
            if ((m0_bus.rd || m0_bus.wr) && (m1_bus.rd || m1_bus.wr)) mdl_owner = 1 - mdl_last;
            else if (m0_bus.rd || m0_bus.wr) mdl_owner = 0;
            else if (m1_bus.rd || m1_bus.wr) mdl_owner = 1;
            mdl_beats = 0;
            mdl_stall = 0;
        end else begin
            if (ram_bus.data_valid) begin
                mdl_beats = mdl_beats + 1;
                mdl_stall = 0;
                if (mdl_beats == BURST_LEN) begin
                    mdl_last  = mdl_owner;
                    mdl_owner = -1;
                    mdl_beats = 0;
                end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (mdl_stall == TIMEOUT) begin
                mdl_last    = mdl_owner;
                mdl_owner   = -1;
                mdl_beats   = 0;
                mdl_stall   = 0;
                mdl_timeout = 1'b1;
            end else begin
                mdl_stall = mdl_stall + 1;
            end
`endif
        end
    end

    logic [6:0]      obs_ctrl, exp_ctrl;
    logic [AW+95:0]  obs_data, exp_data;

    assign obs_ctrl = {grant, ram_bus.rd, ram_bus.wr, m0_bus.data_valid, m1_bus.data_valid, arb_timeout};
    assign obs_data = {ram_bus.address, ram_bus.data_wr, m0_bus.data_rd, m1_bus.data_rd};

    always_comb begin
        exp_ctrl = {6'b000000, mdl_timeout};
        exp_data = '0;
        if (mdl_owner == 0) begin
            exp_ctrl = {2'b01, m0_bus.rd, m0_bus.wr, ram_bus.data_valid, 1'b0, mdl_timeout};
            exp_data = {m0_bus.address, m0_bus.data_wr, ram_bus.data_rd, ram_bus.data_rd};
        end else if (mdl_owner == 1) begin
            exp_ctrl = {2'b10, m1_bus.rd, m1_bus.wr, 1'b0, ram_bus.data_valid, mdl_timeout};
            exp_data = {m1_bus.address, m1_bus.data_wr, ram_bus.data_rd, ram_bus.data_rd};
        end
    end

    // Move to just after the next rising edge and present fresh read data.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        ram_bus.data_rd = $urandom;
    endtask

    task automatic do_reset();
        next_cycle();
        m0_bus.rd = 1'b0; m0_bus.wr = 1'b0; m0_bus.address = '0; m0_bus.data_wr = '0;
        m1_bus.rd = 1'b0; m1_bus.wr = 1'b0; m1_bus.address = '0; m1_bus.data_wr = '0;
        ram_bus.data_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1;
        m0_bus.rd = 1'b1; m0_bus.address = 16'h1234; m0_bus.data_wr = $urandom;
        m1_bus.wr = 1'b1; m1_bus.address = 16'hBEEC; m1_bus.data_wr = $urandom;
        ram_bus.data_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs_ctrl !== 7'b0) begin
                failures++;
                $display("[TB] FAIL reset_ctrl cycle=%0d got=%b expected=%b", c, obs_ctrl, 7'b0);
            end
            checks++;
            if (obs_data !== '0) begin
                failures++;
                $display("[TB] FAIL reset_data cycle=%0d got=%h expected=0", c, obs_data);
            end
            next_cycle();
        end
        m0_bus.rd = 1'b0; m1_bus.wr = 1'b0; ram_bus.data_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int         beats0;
        int         beats1;
        logic [15:0] base;
        beats0 = 0;
        beats1 = 0;
        do_reset();
        base = 16'($urandom_range(0, 16'h0FFF)) << 4;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            m0_bus.rd          = (beats0 < BURST_LEN);
            m0_bus.address     = base + 16'(4 * beats0);
            ram_bus.data_valid = ((c % 2) == 0) && (c <= 8);
            @(negedge clk);
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL single_ctrl cycle=%0d got=%b expected=%b", c, obs_ctrl, exp_ctrl);
            end
            checks++;
            if (obs_data !== exp_data) begin
                failures++;
                $display("[TB] FAIL single_data cycle=%0d got=%h expected=%h", c, obs_data, exp_data);
            end
            if (c == 1) begin
                checks++;
                if (grant !== 2'b01) begin
                    failures++;
                    $display("[TB] FAIL single_grant_latency got=%b expected=01", grant);
                end
            end
            if (c == 9) begin
                checks++;
                if (grant !== 2'b00) begin
                    failures++;
                    $display("[TB] FAIL single_release got=%b expected=00", grant);
                end
            end
            if (m0_bus.data_valid) beats0++;
            if (m1_bus.data_valid) beats1++;
        end
        checks++;
        if (beats0 != BURST_LEN || beats1 != 0) begin
            failures++;
            $display("[TB] FAIL single_beats got=%0d/%0d expected=4/0", beats0, beats1);
        end
    endtask

    task automatic test_tie();
        int         b0;
        int         b1;
        int         n;
        logic [3:0] order;
        logic [1:0] prev;
        bit         done;
        b0 = 0; b1 = 0; n = 0; order = '0; prev = 2'b00; done = 1'b0;
        do_reset();
        for (int c = 0; c < 200 && !done; c++) begin
            next_cycle();
            m0_bus.rd          = (b0 < BURST_LEN);
            m1_bus.rd          = (b1 < BURST_LEN);
            m0_bus.address     = 16'h2000 + 16'(4 * b0);
            m1_bus.address     = 16'h3000 + 16'(4 * b1);
            ram_bus.data_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL tie_ctrl cycle=%0d got=%b expected=%b", c, obs_ctrl, exp_ctrl);
            end
            checks++;
            if (obs_data !== exp_data) begin
                failures++;
                $display("[TB] FAIL tie_data cycle=%0d got=%h expected=%h", c, obs_data, exp_data);
            end
            if (grant != prev && grant != 2'b00) begin
                order = {order[1:0], grant};
                n++;
            end
            prev = grant;
            if (m0_bus.data_valid) b0++;
            if (m1_bus.data_valid) b1++;
            if (b0 == BURST_LEN && b1 == BURST_LEN && grant == 2'b00) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL tie_timeout got=%0d/%0d beats expected=4/4", b0, b1);
        end
        checks++;
        if (n != 2 || order !== 4'b0110) begin
            failures++;
            $display("[TB] FAIL tie_order got=%0d grants order=%b expected=2 grants order=0110", n, order);
        end
        next_cycle();
        m0_bus.rd = 1'b1; m1_bus.rd = 1'b1; ram_bus.data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_ctrl !== exp_ctrl) begin
            failures++;
            $display("[TB] FAIL tie2_ctrl got=%b expected=%b", obs_ctrl, exp_ctrl);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("[TB] FAIL tie_second got=%b expected=01", grant);
        end
    endtask

    task automatic test_back_to_back();
        int         b0;
        int         b1;
        int         ph0;
        int         n;
        logic [5:0] order;
        logic [1:0] prev;
        bit         done;
        b0 = 0; b1 = 0; ph0 = 0; n = 0; order = '0; prev = 2'b00; done = 1'b0;
        do_reset();
        for (int c = 0; c < 300 && !done; c++) begin
            next_cycle();
            m0_bus.wr          = (ph0 == 0);
            m0_bus.rd          = (ph0 == 1);
            m0_bus.address     = ((ph0 == 0) ? 16'h1230 : 16'h5670) + 16'(4 * b0);
            m0_bus.data_wr     = $urandom;
            m1_bus.rd          = (b1 < BURST_LEN);
            m1_bus.address     = 16'h9000 + 16'(4 * b1);
            ram_bus.data_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL b2b_ctrl cycle=%0d got=%b expected=%b", c, obs_ctrl, exp_ctrl);
            end
            checks++;
            if (obs_data !== exp_data) begin
                failures++;
                $display("[TB] FAIL b2b_data cycle=%0d got=%h expected=%h", c, obs_data, exp_data);
            end
            if (grant != 2'b00) begin
                checks++;
                if ((grant == 2'b01 && ram_bus.address[15:12] == 4'h9) ||
                    (grant == 2'b10 && ram_bus.address[15:12] != 4'h9)) begin
                    failures++;
                    $display("[TB] FAIL b2b_mix cycle=%0d grant=%b address=%h", c, grant, ram_bus.address);
                end
            end
            if (grant != prev && grant != 2'b00) begin
                order = {order[3:0], grant};
                n++;
            end
            prev = grant;
            if (m0_bus.data_valid) begin
                b0++;
                if (b0 == BURST_LEN) begin
                    ph0++;
                    b0 = 0;
                end
            end
            if (m1_bus.data_valid) b1++;
            if (ph0 == 2 && b1 == BURST_LEN && grant == 2'b00) done = 1'b1;
        end
        checks++;
        if (!done || n != 3 || order !== 6'b011001) begin
            failures++;
            $display("[TB] FAIL b2b_order got done=%0d grants=%0d order=%b expected done=1 grants=3 order=011001",
                     done, n, order);
        end
    endtask

    task automatic test_toggle();
        int b0;
        int cyc;
        b0 = 0;
        cyc = 0;
        do_reset();
        while (b0 < BURST_LEN && cyc < 100) begin
            next_cycle();
            m0_bus.rd          = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            m0_bus.address     = 16'h4440 + 16'(4 * b0);
            m1_bus.rd          = 1'b1;
            m1_bus.address     = 16'hA000;
            ram_bus.data_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL toggle_ctrl cycle=%0d got=%b expected=%b", cyc, obs_ctrl, exp_ctrl);
            end
            if (cyc >= 1) begin
                checks++;
                if (grant !== 2'b01) begin
                    failures++;
                    $display("[TB] FAIL toggle_lock cycle=%0d got=%b expected=01", cyc, grant);
                end
            end
            if (m0_bus.data_valid) b0++;
            cyc++;
        end
        checks++;
        if (b0 != BURST_LEN) begin
            failures++;
            $display("[TB] FAIL toggle_timeout got=%0d beats expected=4", b0);
        end
        next_cycle();
        m0_bus.rd = 1'b0; ram_bus.data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("[TB] FAIL toggle_gap got=%b expected=00", grant);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("[TB] FAIL toggle_handover got=%b expected=10", grant);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        int b1;
        int gcount;
        b0 = 0; b1 = 0; gcount = 0;
        do_reset();
        for (int c = 0; c < 40 && b1 < 2; c++) begin
            next_cycle();
            m1_bus.rd          = 1'b1;
            m1_bus.address     = 16'h7000 + 16'(4 * b1);
            ram_bus.data_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL rstmid_ctrl cycle=%0d got=%b expected=%b", c, obs_ctrl, exp_ctrl);
            end
            if (m1_bus.data_valid) b1++;
        end
        checks++;
        if (b1 != 2) begin
            failures++;
            $display("[TB] FAIL rstmid_timeout got=%0d beats expected=2", b1);
        end
        next_cycle();
        ram_bus.data_valid = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("[TB] FAIL rstmid_pre got=%b expected=10", grant);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs_ctrl !== 7'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_async got=%b expected=%b", obs_ctrl, 7'b0);
        end
        checks++;
        if (obs_data !== '0) begin
            failures++;
            $display("[TB] FAIL rstmid_data got=%h expected=0", obs_data);
        end
        next_cycle();
        rst = 1'b0;
        m1_bus.rd = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            m0_bus.rd          = (b0 < BURST_LEN);
            m0_bus.address     = 16'h0400 + 16'(4 * b0);
            ram_bus.data_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL rstmid_after cycle=%0d got=%b expected=%b", c, obs_ctrl, exp_ctrl);
            end
            if (grant == 2'b01) gcount++;
            if (m0_bus.data_valid) b0++;
        end
        checks++;
        if (gcount != BURST_LEN) begin
            failures++;
            $display("[TB] FAIL rstmid_burst_len got=%0d granted cycles expected=4", gcount);
        end
    endtask

    task automatic test_stall();
        bit saw10;
        saw10 = 1'b0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            m0_bus.rd          = 1'b1;
            m0_bus.address     = 16'h6660;
            m1_bus.rd          = 1'b1;
            m1_bus.address     = 16'hB000;
            ram_bus.data_valid = (c == 2);
            @(negedge clk);
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                failures++;
                $display("[TB] FAIL stall_ctrl cycle=%0d got=%b expected=%b", c, obs_ctrl, exp_ctrl);
            end
            if (grant == 2'b10) saw10 = 1'b1;
`ifndef MEM_ARB_TIMEOUT_EN
            if (c >= 1) begin
                checks++;
                if (grant !== 2'b01 || arb_timeout !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_hold cycle=%0d got grant=%b timeout=%b expected grant=01 timeout=0",
                             c, grant, arb_timeout);
                end
            end
`endif
        end
`ifdef MEM_ARB_TIMEOUT_EN
        checks++;
        if (arb_timeout !== 1'b1 || !saw10) begin
            failures++;
            $display("[TB] FAIL stall_timeout got timeout=%b port1_granted=%0d expected 1/1", arb_timeout, saw10);
        end
`endif
    endtask

    initial begin
        m0_bus.rd = 1'b0; m0_bus.wr = 1'b0; m0_bus.address = '0; m0_bus.data_wr = '0;
        m1_bus.rd = 1'b0; m1_bus.wr = 1'b0; m1_bus.address = '0; m1_bus.data_wr = '0;
        ram_bus.data_valid = 1'b0;
        ram_bus.data_rd    = '0;
        $display("[TB] ram_arbiter bench start");
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_toggle();
        test_reset_mid();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t checks=%0d", $time, checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
